// File: rtl/branch_resolve_ctrl.sv
// Branch resolve sequencer: gates the branch type into the ID-stage condition
// checker once operands are final, freezes the front end while waiting, and
// issues a registered PC redirect plus IF/ID flush on taken branches.
module branch_resolve_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WAIT_LIMIT   = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic [1:0]       BR_Type,
    input  logic [31:0]      br_target,
    input  logic             operands_ready,
    input  logic             branch_taken,
    output logic [1:0]       cc_BR_Type,
    output logic             freeze,
    output logic             flush,
    output logic             pc_sel,
    output logic [31:0]      pc_target,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam int unsigned FCNT_W = 4;
    localparam int unsigned WCNT_W = 8;
    localparam int unsigned ADDR_W = 32;
    localparam logic [1:0]  BT_NONE = 2'b00;
    localparam logic [1:0]  BT_JMP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          type_q, type_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                flush_q, flush_d;
    logic                pc_sel_q, pc_sel_d;
    logic [ADDR_W-1:0]   pc_target_q, pc_target_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]    tk_cnt_q, tk_cnt_d;

    logic                req;
    logic                resolve;
    logic [ADDR_W-1:0]   redirect_tgt;
    logic [1:0]          cc_type_c;
    logic                freeze_c;

    assign req = br_valid && (BR_Type != BT_NONE);

    // Next-state, checker gating, freeze and statistics update
    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        target_d     = target_q;
        wait_cnt_d   = wait_cnt_q;
        fcnt_d       = fcnt_q;
        flush_d      = 1'b0;
        pc_sel_d     = 1'b0;
        pc_target_d  = pc_target_q;
        timeout_d    = timeout_q;
        br_cnt_d     = br_cnt_q;
        tk_cnt_d     = tk_cnt_q;
        cc_type_c    = BT_NONE;
        freeze_c     = 1'b0;
        resolve      = 1'b0;
        redirect_tgt = target_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    type_d       = BR_Type;
                    target_d     = br_target;
                    redirect_tgt = br_target;
                    if (operands_ready || (BR_Type == BT_JMP)) begin
                        cc_type_c = BR_Type;
                        resolve   = 1'b1;
                    end else begin
                        freeze_c   = 1'b1;
                        state_d    = ST_WAIT;
                        wait_cnt_d = WCNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (operands_ready) begin
                    cc_type_c = type_q;
                    resolve   = 1'b1;
                end else begin
                    freeze_c = 1'b1;
                    if (wait_cnt_q != '1) begin
                        wait_cnt_d = WCNT_W'(wait_cnt_q + WCNT_W'(1));
                    end
                end
            end
            ST_FLUSH: begin
                // ID content is being squashed; requests are not looked at
                if (fcnt_q <= FCNT_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d  = FCNT_W'(fcnt_q - FCNT_W'(1));
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (resolve) begin
            if (br_cnt_q != '1) begin
                br_cnt_d = CNT_W'(br_cnt_q + CNT_W'(1));
            end
            if (branch_taken) begin
                if (tk_cnt_q != '1) begin
                    tk_cnt_d = CNT_W'(tk_cnt_q + CNT_W'(1));
                end
                pc_sel_d    = 1'b1;
                pc_target_d = redirect_tgt;
                flush_d     = 1'b1;
                fcnt_d      = FCNT_W'(FLUSH_CYCLES);
                state_d     = ST_FLUSH;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // Sticky once the wait has lasted WAIT_LIMIT cycles; the wait continues
        if ((state_d == ST_WAIT) && (wait_cnt_d >= WCNT_W'(WAIT_LIMIT))) begin
            timeout_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            type_q      <= BT_NONE;
            target_q    <= '0;
            wait_cnt_q  <= '0;
            fcnt_q      <= '0;
            flush_q     <= 1'b0;
            pc_sel_q    <= 1'b0;
            pc_target_q <= '0;
            timeout_q   <= 1'b0;
            br_cnt_q    <= '0;
            tk_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            target_q    <= target_d;
            wait_cnt_q  <= wait_cnt_d;
            fcnt_q      <= fcnt_d;
            flush_q     <= flush_d;
            pc_sel_q    <= pc_sel_d;
            pc_target_q <= pc_target_d;
            timeout_q   <= timeout_d;
            br_cnt_q    <= br_cnt_d;
            tk_cnt_q    <= tk_cnt_d;
        end
    end

    assign cc_BR_Type   = cc_type_c;
    assign freeze       = freeze_c;
    assign flush        = flush_q;
    assign pc_sel       = pc_sel_q;
    assign pc_target    = pc_target_q;
    assign busy         = (state_q != ST_IDLE);
    assign timeout_err  = timeout_q;
    assign branch_count = br_cnt_q;
    assign taken_count  = tk_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: default instance plus a narrow-counter,
// two-cycle-flush instance sharing the same stimulus.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic [1:0]  BR_Type;
    logic [31:0] br_target;
    logic        operands_ready;
    logic        branch_taken;

    logic [1:0]  cc_BR_Type;
    logic        freeze, flush, pc_sel, busy, timeout_err;
    logic [31:0] pc_target;
    logic [15:0] branch_count, taken_count;

    logic [1:0]  s_cc_BR_Type;
    logic        s_freeze, s_flush, s_pc_sel, s_busy, s_timeout_err;
    logic [31:0] s_pc_target;
    logic [3:0]  s_branch_count, s_taken_count;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve_ctrl #(.FLUSH_CYCLES(1), .WAIT_LIMIT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .BR_Type(BR_Type),
        .br_target(br_target), .operands_ready(operands_ready),
        .branch_taken(branch_taken), .cc_BR_Type(cc_BR_Type), .freeze(freeze),
        .flush(flush), .pc_sel(pc_sel), .pc_target(pc_target), .busy(busy),
        .timeout_err(timeout_err), .branch_count(branch_count),
        .taken_count(taken_count)
    );

    branch_resolve_ctrl #(.FLUSH_CYCLES(2), .WAIT_LIMIT(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .br_valid(br_valid), .BR_Type(BR_Type),
        .br_target(br_target), .operands_ready(operands_ready),
        .branch_taken(branch_taken), .cc_BR_Type(s_cc_BR_Type), .freeze(s_freeze),
        .flush(s_flush), .pc_sel(s_pc_sel), .pc_target(s_pc_target), .busy(s_busy),
        .timeout_err(s_timeout_err), .branch_count(s_branch_count),
        .taken_count(s_taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        br_valid       = 1'b0;
        BR_Type        = 2'b00;
        br_target      = 32'h0;
        operands_ready = 1'b0;
        branch_taken   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();

        // Reset, then five idle cycles
        do_reset();
        check("rst_busy", busy, 1'b0);
        repeat (5) tick();
        #1;
        check("idle_cc", cc_BR_Type, 2'b00);
        check("idle_freeze", freeze, 1'b0);
        check("idle_flush", flush, 1'b0);
        check("idle_pc_sel", pc_sel, 1'b0);
        check("idle_pc_target", pc_target, 32'h0);
        check("idle_busy", busy, 1'b0);
        check("idle_timeout", timeout_err, 1'b0);
        check("idle_br_cnt", branch_count, 16'd0);
        check("idle_tk_cnt", taken_count, 16'd0);

        // BEZ taken with operands ready
        do_reset();
        br_valid = 1'b1; BR_Type = 2'b01; br_target = 32'h40;
        operands_ready = 1'b1; branch_taken = 1'b1;
        #1;
        check("bez_cc", cc_BR_Type, 2'b01);
        check("bez_freeze", freeze, 1'b0);
        tick();
        idle_inputs();
        check("bez_pc_sel", pc_sel, 1'b1);
        check("bez_pc_target", pc_target, 32'h40);
        check("bez_flush", flush, 1'b1);
        check("bez_busy_n1", busy, 1'b1);
        tick();
        check("bez_pc_sel_n2", pc_sel, 1'b0);
        check("bez_busy_n2", busy, 1'b0);
        check("bez_flush_n2", flush, 1'b0);
        check("bez_br_cnt", branch_count, 16'd1);
        check("bez_tk_cnt", taken_count, 16'd1);

        // BNE waits three cycles, not taken; type changes mid-wait are ignored
        do_reset();
        br_valid = 1'b1; BR_Type = 2'b10; br_target = 32'h80;
        operands_ready = 1'b0; branch_taken = 1'b0;
        #1;
        check("bne_c1_freeze", freeze, 1'b1);
        check("bne_c1_cc", cc_BR_Type, 2'b00);
        tick();
        BR_Type = 2'b11; br_target = 32'h999;
        #1;
        check("bne_c2_freeze", freeze, 1'b1);
        check("bne_c2_cc", cc_BR_Type, 2'b00);
        check("bne_c2_busy", busy, 1'b1);
        tick();
        check("bne_c3_freeze", freeze, 1'b1);
        tick();
        operands_ready = 1'b1;
        #1;
        check("bne_c4_cc", cc_BR_Type, 2'b10);
        check("bne_c4_freeze", freeze, 1'b0);
        tick();
        idle_inputs();
        check("bne_pc_sel", pc_sel, 1'b0);
        check("bne_flush", flush, 1'b0);
        check("bne_busy", busy, 1'b0);
        check("bne_br_cnt", branch_count, 16'd1);
        check("bne_tk_cnt", taken_count, 16'd0);

        // JMP never waits for operands
        do_reset();
        br_valid = 1'b1; BR_Type = 2'b11; br_target = 32'h100;
        operands_ready = 1'b0; branch_taken = 1'b1;
        #1;
        check("jmp_cc", cc_BR_Type, 2'b11);
        check("jmp_freeze", freeze, 1'b0);
        tick();
        idle_inputs();
        check("jmp_pc_sel", pc_sel, 1'b1);
        check("jmp_pc_target", pc_target, 32'h100);
        check("jmp_flush", flush, 1'b1);

        // Timeout after eight wait cycles, latched target, then reset mid-FLUSH
        do_reset();
        br_valid = 1'b1; BR_Type = 2'b01; br_target = 32'h200;
        operands_ready = 1'b0; branch_taken = 1'b0;
        tick();
        BR_Type = 2'b10; br_target = 32'hDEAD;
        repeat (6) tick();
        check("to_before_limit", timeout_err, 1'b0);
        tick();
        check("to_at_limit", timeout_err, 1'b1);
        check("to_still_busy", busy, 1'b1);
        tick();
        tick();
        operands_ready = 1'b1; branch_taken = 1'b1;
        #1;
        check("to_resolve_cc", cc_BR_Type, 2'b01);
        tick();
        idle_inputs();
        check("to_pc_sel", pc_sel, 1'b1);
        check("to_pc_target", pc_target, 32'h200);
        check("to_sticky", timeout_err, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_pc_sel", pc_sel, 1'b0);
        check("mid_rst_flush", flush, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_timeout", timeout_err, 1'b0);
        check("mid_rst_pc_target", pc_target, 32'h0);
        check("mid_rst_br_cnt", branch_count, 16'd0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_pc_sel", pc_sel, 1'b0);
        check("post_rst_flush", flush, 1'b0);

        // Back-to-back JMPs with br_valid held through FLUSH
        do_reset();
        br_valid = 1'b1; BR_Type = 2'b11; br_target = 32'h300;
        operands_ready = 1'b0; branch_taken = 1'b1;
        repeat (30) tick();
        check("b2b_sat_br_cnt", s_branch_count, 4'd10);
        check("b2b_sat_tk_cnt", s_taken_count, 4'd10);
        check("b2b_main_br_cnt", branch_count, 16'd15);
        repeat (27) tick();
        check("sat_br_cnt", s_branch_count, 4'hF);
        check("sat_tk_cnt", s_taken_count, 4'hF);
        repeat (9) tick();
        check("sat_no_wrap", s_branch_count, 4'hF);
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequencer wrapped around the ID-stage branch condition checker.
- Takes branch requests from ID and drives the branch type into the checker only when operands are final.
- Freezes the pipeline while it waits for operands, then samples the taken result.
- On a taken branch, issues a registered PC redirect plus a multi-cycle IF/ID flush. Keeps saturating branch statistics.

Parameters:
FLUSH_CYCLES, 1, number of cycles flush is held after a taken branch (1..15)
WAIT_LIMIT, 8, max cycles in WAIT before the sticky timeout error is set (1..255)
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
br_valid  input  1  ID stage holds a decoded instruction
BR_Type  input  2  ID branch type: 00 none, 01 BEZ, 10 BNE, 11 JMP
br_target  input  32  branch target address from ID
operands_ready  input  1  hazard unit: ID register operands are final
branch_taken  input  1  result from the condition checker (combinational)
cc_BR_Type  output  2  branch type driven into the condition checker
freeze  output  1  hold PC and IF/ID (combinational)
flush  output  1  clear IF/ID register (registered)
pc_sel  output  1  select pc_target into PC (registered, 1-cycle pulse)
pc_target  output  32  redirect address, valid while pc_sel=1
busy  output  1  state != IDLE
timeout_err  output  1  sticky: WAIT exceeded WAIT_LIMIT
branch_count  output  CNT_W  resolved branches, saturating
taken_count  output  CNT_W  taken branches, saturating

Behaviour:
- Reset (rst=0, async): state=IDLE; flush, pc_sel, timeout_err = 0; pc_target=0; both counters=0; internal latches=0.
- req = br_valid && BR_Type!=00.
- ready_eff = operands_ready || type==11. JMP never waits.
- States: IDLE, WAIT, FLUSH.
- IDLE, req=0:
  - cc_BR_Type=00, freeze=0.
  - Stay in IDLE.
- IDLE, req=1:
  - Latch BR_Type and br_target.
  - If ready_eff: cc_BR_Type=BR_Type and this is the resolve cycle.
  - Else: cc_BR_Type=00, freeze=1, next state=WAIT, wait counter=1.
- WAIT:
  - freeze=1.
  - cc_BR_Type = latched type only when operands_ready, else 00.
  - When operands_ready: resolve this cycle.
  - Else: wait counter increments.
  - When the wait counter reaches WAIT_LIMIT: timeout_err<=1, and the block stays in WAIT (no abort).
- Resolve cycle N:
  - Sample branch_taken.
  - branch_count+1.
  - Not taken: next state=IDLE. freeze deasserts in cycle N, so the branch leaves ID normally.
  - Taken:
    - taken_count+1.
    - At N+1: pc_sel=1 and pc_target=latched target.
    - Flush high N+1..N+FLUSH_CYCLES.
    - Next state=FLUSH.
  - freeze=0 in the resolve cycle.
- FLUSH:
  - freeze=0, cc_BR_Type=00.
  - br_valid ignored; the ID content is being squashed and is not counted.
  - pc_sel is low after its first cycle.
  - Flush counter decrements; return to IDLE after the last flush cycle. A req in the first IDLE cycle is honoured.
- Counters saturate at all-ones; no wrap.
- timeout_err is cleared only by reset.
- BR_Type and br_target may change during WAIT (pipeline error). The latched values are used regardless.
- Reset asserted mid-WAIT or mid-FLUSH: immediate return to the reset state. No pc_sel pulse is emitted afterward.
- Latency from resolve to redirect: 1 cycle. Total penalty for a taken branch = FLUSH_CYCLES + wait cycles.

Test Plan:
- Reset release, no req for 5 cycles -> all outputs 0, busy=0, counters 0.
- BEZ, br_target=0x40, operands_ready=1, branch_taken=1 at cycle N:
  - Cycle N: cc_BR_Type=01, freeze=0.
  - Cycle N+1: pc_sel=1, pc_target=0x40, flush=1.
  - Cycle N+2: pc_sel=0, busy=0 (FLUSH_CYCLES=1).
  - branch_count=1, taken_count=1.
- BNE, operands_ready low for 3 cycles then high, branch_taken=0:
  - freeze=1 for 3 cycles, cc_BR_Type=00 during them.
  - Cycle 4: cc_BR_Type=10, freeze=0; no pc_sel or flush.
  - branch_count=1, taken_count=0.
- JMP with operands_ready=0, target=0x100 -> resolves the same cycle; pc_sel=1 and pc_target=0x100 next cycle; no freeze.
- WAIT_LIMIT=8, operands_ready held low for 10 cycles -> timeout_err=1 after the 8th wait cycle and stays 1 through the later resolve. Then drive rst low mid-FLUSH -> all outputs 0 at once, state IDLE.
- 2^CNT_W+3 taken JMPs back-to-back with FLUSH_CYCLES=2 -> both counters saturate at all-ones. br_valid pulses during FLUSH are not counted.
